// File: rtl/alu_iter_pkg.sv
// alu_iter_pkg: function codes, flag layout, FSM states and helpers shared by
// the iterative ALU. Optional macro ALU_DIV_EN enables the iterative divider.
package alu_iter_pkg;

    localparam int unsigned ALU_FUNC_W = 4;
    localparam int unsigned FR_FLAG_W  = 4;

    // Existing single-cycle codes keep their values; iterative codes are new.
    localparam logic [ALU_FUNC_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_FUNC_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_FUNC_W-1:0] ALU_TH   = 4'd2;
    localparam logic [ALU_FUNC_W-1:0] ALU_NOT  = 4'd3;
    localparam logic [ALU_FUNC_W-1:0] ALU_AND  = 4'd4;
    localparam logic [ALU_FUNC_W-1:0] ALU_OR   = 4'd5;
    localparam logic [ALU_FUNC_W-1:0] ALU_XOR  = 4'd6;
    localparam logic [ALU_FUNC_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_FUNC_W-1:0] ALU_SRL  = 4'd8;
    localparam logic [ALU_FUNC_W-1:0] ALU_SLL  = 4'd9;
    localparam logic [ALU_FUNC_W-1:0] ALU_MUL  = 4'd10;
    localparam logic [ALU_FUNC_W-1:0] ALU_MULH = 4'd11;
    localparam logic [ALU_FUNC_W-1:0] ALU_DIV  = 4'd12;
    localparam logic [ALU_FUNC_W-1:0] ALU_MOD  = 4'd13;

    // Flag vector is {N,Z,C,V}
    localparam logic [FR_FLAG_W-1:0] FLAGS_ILLEGAL_OP = 4'b0101;

    typedef enum logic [1:0] {
        ALU_ST_IDLE = 2'd0,
        ALU_ST_BUSY = 2'd1,
        ALU_ST_DONE = 2'd2
    } alu_state_e;

    // True for functions that run through the multi-cycle datapath.
    function automatic logic is_iter_func(input logic [ALU_FUNC_W-1:0] f);
        logic r;
        r = (f == ALU_MUL) || (f == ALU_MULH);
`ifdef ALU_DIV_EN
        r = r || (f == ALU_DIV) || (f == ALU_MOD);
`endif
        return r;
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// alu_iter_core: combinational single-cycle function unit (add/sub, pass,
// logic, shifts) with the N,Z,C,V flag equations. Without ALU_DIV_EN the
// DIV/MOD codes resolve here as an illegal op.
module alu_iter_core
    import alu_iter_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SH_W   = $clog2(DATA_W)
) (
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic [ALU_FUNC_W-1:0] func,
    output logic [DATA_W-1:0]     y,
    output logic [FR_FLAG_W-1:0]  flags
);

    localparam int unsigned       M     = DATA_W - 1;
    localparam logic [DATA_W-1:0] W_VAL = DATA_W'(DATA_W);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] sll_ext;
    logic [DATA_W:0] srl_ext;
    logic [DATA_W:0] sra_ext;
    logic [SH_W:0]   amt;
    logic            c;
    logic            v;
    logic            legal;
    logic            illegal_div;

    // Result and flags for every single-cycle function code
    always_comb begin
        sum         = '0;
        y           = '0;
        c           = 1'b0;
        v           = 1'b0;
        legal       = 1'b1;
        illegal_div = 1'b0;
        // Only meaningful when 1 <= b <= DATA_W; the extra bit captures the
        // last bit shifted out.
        amt         = b[SH_W:0];
        sll_ext     = {1'b0, a} << amt;
        srl_ext     = {a, 1'b0} >> amt;
        sra_ext     = $signed({a, 1'b0}) >>> amt;
        case (func)
            ALU_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                y   = sum[M:0];
                c   = sum[DATA_W];
                v   = (a[M] == b[M]) && (y[M] != a[M]);
            end
            ALU_SUB: begin
                sum = {1'b0, a} - {1'b0, b};
                y   = sum[M:0];
                c   = sum[DATA_W];
                v   = (a[M] != b[M]) && (y[M] != a[M]);
            end
            ALU_TH:  y = b;
            ALU_NOT: y = ~b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_SRA: begin
                if (b == '0) begin
                    y = a;
                end else if (b <= W_VAL) begin
                    y = sra_ext[DATA_W:1];
                    c = sra_ext[0];
                end else begin
                    y = {DATA_W{a[M]}};
                    c = a[M];
                end
            end
            ALU_SRL: begin
                if (b == '0) begin
                    y = a;
                end else if (b <= W_VAL) begin
                    y = srl_ext[DATA_W:1];
                    c = srl_ext[0];
                end
            end
            ALU_SLL: begin
                if (b == '0) begin
                    y = a;
                end else if (b <= W_VAL) begin
                    y = sll_ext[M:0];
                    c = sll_ext[DATA_W];
                end
            end
`ifndef ALU_DIV_EN
            ALU_DIV, ALU_MOD: illegal_div = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
        flags = {y[M], (y == '0), c, v};
        if (!legal) begin
            flags = '0;
        end
        if (illegal_div) begin
            flags = FLAGS_ILLEGAL_OP;
        end
    end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU with registered result, single-cycle functions via
// alu_iter_core and iterative shift-add multiply / restoring divide.
// Optional macro ALU_DIV_EN compiles in the divider; otherwise DIV/MOD are
// reported as an illegal op in one cycle.
`ifndef DATA_W
`define DATA_W 16
`endif

module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int unsigned DATA_W = `DATA_W,
    parameter int unsigned SH_W   = $clog2(DATA_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic [ALU_FUNC_W-1:0] func,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     y,
    output logic [FR_FLAG_W-1:0]  flags
);

    alu_state_e              state;
    alu_state_e              state_nxt;
    logic                    accept;
    logic                    busy;
    logic                    last_iter;
    logic [SH_W-1:0]         cnt;
    logic [ALU_FUNC_W-1:0]   op_func;
    logic [DATA_W-1:0]       op_a;
    logic [DATA_W-1:0]       cur_a;
    logic [2*DATA_W-1:0]     acc;
    logic [2*DATA_W-1:0]     acc_src;
    logic [2*DATA_W-1:0]     acc_nxt;
    logic [DATA_W:0]         mul_sum;
    logic [DATA_W-1:0]       core_y;
    logic [FR_FLAG_W-1:0]    core_flags;
    logic [DATA_W-1:0]       res_y;
    logic                    res_c;
    logic                    res_v;
    logic [FR_FLAG_W-1:0]    res_flags;
`ifdef ALU_DIV_EN
    logic [DATA_W-1:0]       op_b;
    logic [DATA_W-1:0]       cur_b;
    logic                    cur_div;
    logic [DATA_W:0]         div_sh;
`endif

    alu_iter_core #(
        .DATA_W (DATA_W),
        .SH_W   (SH_W)
    ) u_core (
        .a     (a),
        .b     (b),
        .func  (func),
        .y     (core_y),
        .flags (core_flags)
    );

    assign busy      = (state == ALU_ST_BUSY);
    assign last_iter = busy && (cnt == SH_W'(DATA_W - 2));

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ALU_ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs and next-state selection
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            ALU_ST_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) begin
                    state_nxt = is_iter_func(func) ? ALU_ST_BUSY : ALU_ST_DONE;
                end
            end
            ALU_ST_BUSY: begin
                if (last_iter) begin
                    state_nxt = ALU_ST_DONE;
                end
            end
            ALU_ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                accept    = in_valid && out_ready;
                if (out_ready) begin
                    if (accept) begin
                        state_nxt = is_iter_func(func) ? ALU_ST_BUSY : ALU_ST_DONE;
                    end else begin
                        state_nxt = ALU_ST_IDLE;
                    end
                end
            end
            default: state_nxt = ALU_ST_IDLE;
        endcase
    end

    // One multiply/divide step; the accept edge itself runs the first step
    // on the live operands so the result lands DATA_W cycles after accept.
    always_comb begin
        cur_a   = busy ? op_a : a;
        acc_src = busy ? acc : {{DATA_W{1'b0}}, b};
        mul_sum = {1'b0, acc_src[2*DATA_W-1:DATA_W]}
                + (acc_src[0] ? {1'b0, cur_a} : {(DATA_W+1){1'b0}});
        acc_nxt = {mul_sum, acc_src[DATA_W-1:1]};
`ifdef ALU_DIV_EN
        cur_b   = busy ? op_b : b;
        cur_div = busy ? ((op_func == ALU_DIV) || (op_func == ALU_MOD))
                       : ((func == ALU_DIV) || (func == ALU_MOD));
        if (!busy && cur_div) begin
            acc_src = {{DATA_W{1'b0}}, a};
        end
        div_sh = {acc_src[2*DATA_W-1:DATA_W], acc_src[DATA_W-1]};
        if (cur_div) begin
            if (div_sh >= {1'b0, cur_b}) begin
                acc_nxt = {div_sh[DATA_W-1:0] - cur_b, acc_src[DATA_W-2:0], 1'b1};
            end else begin
                acc_nxt = {div_sh[DATA_W-1:0], acc_src[DATA_W-2:0], 1'b0};
            end
        end
`endif
    end

    // Final result and flags of an iterative function, taken from the last step
    always_comb begin
        res_y = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op_func)
            ALU_MUL: begin
                res_y = acc_nxt[DATA_W-1:0];
                res_c = |acc_nxt[2*DATA_W-1:DATA_W];
            end
            ALU_MULH: res_y = acc_nxt[2*DATA_W-1:DATA_W];
`ifdef ALU_DIV_EN
            ALU_DIV: begin
                res_y = acc_nxt[DATA_W-1:0];
                res_v = (op_b == '0);
            end
            ALU_MOD: begin
                res_y = acc_nxt[2*DATA_W-1:DATA_W];
                res_v = (op_b == '0);
            end
`endif
            default: ;
        endcase
        res_flags = {res_y[DATA_W-1], (res_y == '0), res_c, res_v};
    end

    // Operand latches, iteration state and the held result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            op_func <= '0;
            op_a    <= '0;
            acc     <= '0;
            y       <= '0;
            flags   <= '0;
`ifdef ALU_DIV_EN
            op_b    <= '0;
`endif
        end else if (accept) begin
            cnt     <= '0;
            op_func <= func;
            op_a    <= a;
`ifdef ALU_DIV_EN
            op_b    <= b;
`endif
            if (is_iter_func(func)) begin
                acc <= acc_nxt;
            end else begin
                y     <= core_y;
                flags <= core_flags;
            end
        end else if (busy) begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (last_iter) begin
                y     <= res_y;
                flags <= res_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter (DATA_W=16). Expected results
// come from a behavioural model; ALU_DIV_EN selects the divider expectations.
module tb_alu_iter;
    import alu_iter_pkg::*;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [15:0] y;
        logic [3:0]  fl;
        logic [7:0]  lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   func;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [3:0]   flags;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_iter #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] f, input logic [15:0] x, input logic [15:0] z);
        exp_t        e;
        logic [16:0] s;
        logic [31:0] w;
        logic        c;
        logic        v;
        logic        undef;
        logic        illegal;
        c = 1'b0; v = 1'b0; undef = 1'b0; illegal = 1'b0;
        e.y = '0; e.lat = 8'd1;
        w = 32'(x) * 32'(z);
        case (f)
            ALU_ADD: begin s = {1'b0, x} + {1'b0, z}; e.y = s[15:0]; c = s[16];
                           v = (x[15] == z[15]) && (e.y[15] != x[15]); end
            ALU_SUB: begin s = {1'b0, x} - {1'b0, z}; e.y = s[15:0]; c = s[16];
                           v = (x[15] != z[15]) && (e.y[15] != x[15]); end
            ALU_TH:  e.y = z;
            ALU_NOT: e.y = ~z;
            ALU_AND: e.y = x & z;
            ALU_OR:  e.y = x | z;
            ALU_XOR: e.y = x ^ z;
            ALU_SLL: begin
                if (z == 0) e.y = x;
                else if (z <= 16) begin w = {16'h0, x} << z; e.y = w[15:0]; c = w[16]; end
            end
            ALU_SRL: begin
                if (z == 0) e.y = x;
                else if (z <= 16) begin w = {x, 16'h0} >> z; e.y = w[31:16]; c = w[15]; end
            end
            ALU_SRA: begin
                if (z == 0) e.y = x;
                else if (z <= 16) begin w = $signed({x, 16'h0}) >>> z; e.y = w[31:16]; c = w[15]; end
                else begin e.y = {16{x[15]}}; c = x[15]; end
            end
            ALU_MUL:  begin e.y = w[15:0]; c = (w[31:16] != 0); e.lat = 8'd16; end
            ALU_MULH: begin e.y = w[31:16]; e.lat = 8'd16; end
`ifdef ALU_DIV_EN
            ALU_DIV: begin e.lat = 8'd16;
                if (z == 0) begin e.y = 16'hFFFF; v = 1'b1; end else e.y = x / z; end
            ALU_MOD: begin e.lat = 8'd16;
                if (z == 0) begin e.y = x; v = 1'b1; end else e.y = x % z; end
`else
            ALU_DIV, ALU_MOD: illegal = 1'b1;
`endif
            default: undef = 1'b1;
        endcase
        e.fl = {e.y[15], (e.y == 0), c, v};
        if (undef) e.fl = 4'b0000;
        if (illegal) e.fl = 4'b0101;
        return e;
    endfunction

    task automatic issue(input logic [3:0] f, input logic [15:0] va, input logic [15:0] vb);
        int n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("issue_ready", in_ready, 1'b1);
        in_valid = 1'b1; func = f; a = va; b = vb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        func = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
        sb.push_back(model(f, va, vb));
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   lat = 1;
        bit   stalled = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready) stalled = 1'b0;
            @(posedge clk); #1; lat++;
        end
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("latency", lat, e.lat);
            if (e.lat > 1) check("busy_in_ready_low", stalled, 1'b1);
            check("y", y, e.y);
            check("flags", flags, e.fl);
            repeat (hold) begin
                @(posedge clk); #1;
                check("hold_valid", out_valid, 1'b1);
                check("hold_y", y, e.y);
                check("hold_flags", flags, e.fl);
                check("hold_in_ready", in_ready, 1'b0);
            end
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_valid", out_valid, 1'b0);
    endtask

    task automatic run(input logic [3:0] f, input logic [15:0] va, input logic [15:0] vb);
        issue(f, va, vb);
        collect(0);
        take();
    endtask

    initial begin
        bit          stale;
        logic [3:0]  rf;
        logic [15:0] ra;
        logic [15:0] rb;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; func = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_y", y, 16'h0);
        check("rst_flags", flags, 4'h0);
        rst_n = 1'b1;

        // Directed vectors, including the shift and divide boundaries
        run(ALU_ADD, 16'h7FFF, 16'h0001);
        run(ALU_SUB, 16'h0000, 16'h0001);
        run(ALU_SUB, 16'h8000, 16'h0001);
        run(ALU_SRA, 16'h8001, 16'd1);
        run(ALU_SLL, 16'h8000, 16'd1);
        run(ALU_SRL, 16'h00FF, 16'd20);
        run(ALU_SRA, 16'h8000, 16'd16);
        run(ALU_SRA, 16'h8000, 16'd17);
        run(ALU_SLL, 16'h0001, 16'd16);
        run(ALU_SRL, 16'h1234, 16'd0);
        run(ALU_MUL, 16'h0100, 16'h0100);
        run(ALU_MULH, 16'h0100, 16'h0100);
        run(ALU_MUL, 16'hFFFF, 16'hFFFF);
        run(ALU_DIV, 16'd100, 16'd7);
        run(ALU_MOD, 16'd100, 16'd7);
        run(ALU_DIV, 16'd5, 16'd0);
        run(ALU_MOD, 16'd5, 16'd0);
        run(ALU_TH, 16'h1111, 16'h0000);
        run(ALU_NOT, 16'h1111, 16'h00FF);
        run(ALU_XOR, 16'hA5A5, 16'hA5A5);
        run(4'd14, 16'h1234, 16'h5678);
        run(4'd15, 16'h0000, 16'h0000);

        // Back-pressure then back-to-back accept in the release cycle
        issue(ALU_MUL, 16'h0003, 16'h0005);
        collect(3);
        out_ready = 1'b1;
        issue(ALU_ADD, 16'd1, 16'd1);
        out_ready = 1'b0;
        collect(0);
        take();

        // Random operations, with small shift amounts now and then
        for (int i = 0; i < 40; i++) begin
            rf = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            run(rf, ra, rb);
        end

        // Reset in the middle of a multiply discards it
        issue(ALU_MUL, 16'h0100, 16'h0100);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_y", y, 16'h0);
        check("abort_flags", flags, 4'h0);
        rst_n = 1'b1;
        sb.delete();
        stale = 1'b0;
        repeat (25) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1'b1;
        end
        check("no_stale_result", stale, 1'b0);
        run(ALU_ADD, 16'd2, 16'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
